// File: rtl/seg_scan_mux_pkg.sv
// Shared types for the multiplexed seven-segment scanner.
package seg_scan_pkg;
   typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_t;
   typedef logic [3:0] digit_t;
endpackage

// File: rtl/seg_scan_mux_if.sv
// Digit-load handshake between the digit producer and the scanner.
interface seg_scan_mux_if
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);
   digit_t [NUM_DIGITS-1:0] load_data;
   logic                    load_valid;
   logic                    load_ready;

   modport master (output load_data, load_valid, input load_ready);
   modport slave  (input load_data, load_valid, output load_ready);
endinterface

// File: rtl/seg_scan_mux_slot_timer.sv
// Slot counter, BLANK/DRIVE phase and digit index for the scanner.
module slot_timer
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DWELL_COUNT = 100_000,
   parameter int BLANK_COUNT = 500,
   parameter int CW          = $clog2(DWELL_COUNT),
   parameter int IW          = $clog2(NUM_DIGITS)
) (
   input  logic          clk,
   input  logic          reset,
   output logic [CW-1:0] count,
   output logic [IW-1:0] idx,
   output scan_state_t   state,
   output logic          frame_done
);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL_COUNT - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_COUNT - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         idx   <= '0;
         state <= BLANK;
      end else if (count == CNT_LAST) begin
         count <= '0;
         state <= BLANK;
         idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         count <= count + 1'b1;
         if (count == BLANK_LAST)
            state <= DRIVE;
      end
   end

   assign frame_done = (idx == IDX_LAST) && (count == CNT_LAST);
endmodule

// File: rtl/seg_scan_mux.sv
// N-digit seven-segment scanner with frame-synchronous loads, blank mask
// and leading-zero suppression.
module seg_scan_mux
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DWELL_COUNT = 100_000,
   parameter int BLANK_COUNT = 500
) (
   input  logic                  clk,
   input  logic                  reset,
   seg_scan_mux_if.slave         ld,
   input  logic [NUM_DIGITS-1:0] digit_mask,
   input  logic                  lz_en,
   output logic [NUM_DIGITS-1:0] digit_en,
   output digit_t                seg_data,
   output logic                  frame_done
);
   localparam int CW = $clog2(DWELL_COUNT);
   localparam int IW = $clog2(NUM_DIGITS);

   logic [CW-1:0]           count;
   logic [IW-1:0]           idx;
   scan_state_t             state;
   digit_t [NUM_DIGITS-1:0] pending, active;
   logic                    pending_full;
   logic [NUM_DIGITS-1:0]   mask_q, nz, suppress;
   logic                    lz_q;

   slot_timer #(
      .NUM_DIGITS (NUM_DIGITS),
      .DWELL_COUNT(DWELL_COUNT),
      .BLANK_COUNT(BLANK_COUNT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .count     (count),
      .idx       (idx),
      .state     (state),
      .frame_done(frame_done)
   );

   assign ld.load_ready = !pending_full;

   // A load on the frame_done cycle can only land in an empty pending
   // buffer, so commit and accept never collide on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending      <= '0;
         active       <= '0;
         pending_full <= 1'b0;
      end else begin
         if (frame_done && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
         end
         if (ld.load_valid && !pending_full) begin
            pending      <= ld.load_data;
            pending_full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
         lz_q   <= 1'b0;
      end else if (count == '0) begin
         mask_q <= digit_mask;
         lz_q   <= lz_en;
      end
   end

   // Digit i is a leading zero when it and every higher digit are zero.
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      assign nz[i] = |active[i];
      if (i == 0) begin : g_lsd
         assign suppress[i] = 1'b0;
      end else begin : g_hi
         assign suppress[i] = lz_q && !(|nz[NUM_DIGITS-1:i]);
      end
      assign digit_en[i] = (state == DRIVE) && (idx == IW'(i)) &&
                           !mask_q[i] && !suppress[i];
   end

   assign seg_data = active[idx];
endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux with a frame-position model and load scoreboard.
module tb_seg_scan_mux;
   import seg_scan_pkg::*;

   localparam int ND    = 4;
   localparam int DW    = 8;
   localparam int BC    = 2;
   localparam int FRAME = ND * DW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [ND-1:0] digit_mask = '0;
   logic          lz_en = 1'b0;
   logic [ND-1:0] digit_en;
   digit_t        seg_data;
   logic          frame_done;

   seg_scan_mux_if #(.NUM_DIGITS(ND)) ld();

   seg_scan_mux #(
      .NUM_DIGITS (ND),
      .DWELL_COUNT(DW),
      .BLANK_COUNT(BC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ld        (ld),
      .digit_mask(digit_mask),
      .lz_en     (lz_en),
      .digit_en  (digit_en),
      .seg_data  (seg_data),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          pos = 0;
   int          cyc = 0;
   int          last_fd = -1;
   int          acc_cnt = 0;
   logic [15:0] exp_q[$];
   logic [15:0] m_active = '0;
   logic        m_pfull = 1'b0;
   logic [3:0]  m_mask = '0;
   logic        m_lz = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int          e_idx, e_cnt;
      logic        sup;
      logic [3:0]  e_en;
      logic [15:0] upper;
      e_idx = pos / DW;
      e_cnt = pos % DW;
      upper = m_active >> (4 * e_idx);
      sup   = m_lz && (e_idx != 0) && (upper == 16'h0);
      e_en  = '0;
      if (e_cnt >= BC && !m_mask[e_idx] && !sup)
         e_en[e_idx] = 1'b1;
      chk("digit_en", 32'(digit_en), 32'(e_en));
      chk("seg_data", 32'(seg_data), 32'(m_active[4*e_idx +: 4]));
      chk("frame_done", 32'(frame_done), 32'(pos == FRAME - 1));
      chk("load_ready", 32'(ld.load_ready), 32'(!m_pfull));
      if (frame_done) begin
         if (last_fd < 0) chk("fd_first", cyc, FRAME - 1);
         else             chk("fd_period", cyc - last_fd, FRAME);
         last_fd = cyc;
      end
   endtask

   // One clock: model the edge from the inputs held before it, then check after it.
   task automatic tick();
      int   pre;
      logic acc_m;
      if (ld.load_valid && ld.load_ready) acc_cnt++;
      pre = pos;
      @(posedge clk);
      cyc++;
      acc_m = ld.load_valid && !m_pfull;
      if (pre % DW == 0) begin
         m_mask = digit_mask;
         m_lz   = lz_en;
      end
      if (pre == FRAME - 1 && m_pfull) begin
         m_active = exp_q.pop_front();
         m_pfull  = 1'b0;
      end
      if (acc_m) begin
         exp_q.push_back(ld.load_data);
         m_pfull = 1'b1;
      end
      pos = (pre + 1) % FRAME;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic run_to(input int p);
      for (int i = 0; i < FRAME && pos != p; i++) tick();
   endtask

   task automatic run_frames(input int n);
      repeat (n * FRAME) tick();
   endtask

   task automatic do_load(input logic [15:0] d);
      ld.load_data  = d;
      ld.load_valid = 1'b1;
      tick();
      ld.load_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_en"}, 32'(digit_en), 32'h0);
      chk({tag, "_seg"}, 32'(seg_data), 32'h0);
      chk({tag, "_rdy"}, 32'(ld.load_ready), 32'h1);
      chk({tag, "_fd"}, 32'(frame_done), 32'h0);
   endtask

   initial begin
      ld.load_data  = '0;
      ld.load_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b1;

      // scan order
      do_load(16'h4321);
      run_frames(2);

      // tear-free mid-frame update
      run_to(12);
      do_load(16'h8765);
      chk("ready_drop", 32'(ld.load_ready), 32'h0);
      run_frames(2);

      // back-to-back loads, data changed on each frame_done cycle
      run_to(0);
      ld.load_data  = 16'h1111;
      ld.load_valid = 1'b1;
      acc_cnt = 0;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < FRAME; c++) begin
            tick();
            if (pos == FRAME - 1) ld.load_data = ld.load_data + 16'h1111;
         end
         chk("acc_per_frame", acc_cnt, 1);
         acc_cnt = 0;
      end
      ld.load_valid = 1'b0;
      run_frames(1);

      // leading zeros, then mask on top
      lz_en = 1'b1;
      do_load(16'h0050);
      run_frames(2);
      digit_mask = 4'b0010;
      run_frames(2);
      lz_en      = 1'b0;
      digit_mask = '0;

      // async reset during DRIVE of digit 2 with a load pending
      run_to(1);
      do_load(16'h9999);
      run_to(20);
      chk("pre_rst_pending", 32'(ld.load_ready), 32'h0);
      #2 reset = 1'b0;
      #1 check_reset_outputs("async_rst");
      exp_q.delete();
      m_active = '0;
      m_pfull  = 1'b0;
      m_mask   = '0;
      m_lz     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst_hold");
      reset   = 1'b1;
      pos     = 0;
      cyc     = 0;
      last_fd = -1;
      run_frames(1);
      do_load(16'h0042);
      run_frames(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised N-digit time-multiplexed seven-segment scanner, the multi-digit successor to the two-digit display controller. It sits between the digit-producing logic (adder, counters, switch inputs) and the hex-to-segment decoder and the board's digit-enable transistors. It adds three things:
- frame-synchronous, tear-free digit updates through a valid/ready load handshake;
- a per-digit blank mask;
- optional leading-zero suppression.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; must be ≥2.
- DWELL_COUNT, 100_000: clock cycles per digit slot (~2 ms at 48 MHz).
- BLANK_COUNT, 500: dark cycles at the start of each slot; requires 1 ≤ BLANK_COUNT < DWELL_COUNT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- load_data  in  4*NUM_DIGITS  new digit values; nibble i = digit i.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  pending buffer is empty and can accept a load.
- digit_mask  in  NUM_DIGITS  bit i = 1 keeps digit i dark for its whole slot.
- lz_en  in  1  enable leading-zero suppression.
- digit_en  out  NUM_DIGITS  one-hot-or-zero digit enable; bit i drives digit i.
- seg_data  out  4  nibble for the segment decoder.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

## Operation
- A slot counter (0..DWELL_COUNT-1) and a digit index (0..NUM_DIGITS-1) scan digits in order 0,1,…,N-1, then wrap to 0.
- FSM states:
  - BLANK: counter < BLANK_COUNT; digit_en = 0.
  - DRIVE: counter ≥ BLANK_COUNT; digit_en = one-hot(idx) unless the digit is suppressed.
  - BLANK→DRIVE when counter == BLANK_COUNT-1.
  - DRIVE→BLANK when counter == DWELL_COUNT-1; on this transition idx increments, wrapping to 0.
- seg_data = active[idx] in both states. Data is preloaded during BLANK so the decoder settles before the digit turns on.
- Masking: digit_mask and lz_en are sampled into registers on the first cycle of each slot (counter == 0). They apply to the whole slot, and no input reaches an output combinationally.
- Leading-zero suppression: with lz_en set, digit i is suppressed when every active digit j ≥ i equals 0. Digit 0 is never suppressed by LZ. A suppressed or masked digit holds digit_en = 0 during DRIVE; its timing is unchanged.
- Load handshake:
  - A transfer occurs on a cycle with load_valid && load_ready. load_data is captured into a pending register, and pending_full is set.
  - load_ready = !pending_full.
- Commit: at the clock edge ending a frame (frame_done high), if pending_full then active ← pending and pending_full clears. load_ready returns high the following cycle.
- Load accepted on the frame_done cycle: goes into pending and commits at the next frame end, never the same edge.
- Reset asserted mid-frame: all state clears immediately and asynchronously; the pending load is discarded.

## Timing
- Reset values:
  - counter = 0, idx = 0, state = BLANK.
  - active = 0, pending = 0, pending_full = 0.
  - mask and LZ registers = 0.
  - Outputs: digit_en = 0, seg_data = 0, frame_done = 0, load_ready = 1.
- Outputs are combinational decodes of registered state only.
- Frame period = NUM_DIGITS × DWELL_COUNT cycles. Each digit is on for DWELL_COUNT − BLANK_COUNT cycles per frame.
- frame_done is high when idx == NUM_DIGITS-1 and counter == DWELL_COUNT-1.
- Load-to-display latency: from the accepting edge to the first DRIVE cycle of digit 0 with the new data, at most 2 frames + BLANK_COUNT cycles.
- Counter width: $clog2(DWELL_COUNT). Index width: $clog2(NUM_DIGITS). Neither ever exceeds its terminal value.

## Structure
- Package seg_scan_pkg holds:
  - typedef enum {BLANK, DRIVE} scan_state_t;
  - typedef logic [3:0] digit_t;
- Sub-module slot_timer owns the slot counter, BLANK/DRIVE state, digit index, and frame_done. It is parametrised by DWELL_COUNT, BLANK_COUNT and NUM_DIGITS.
- The top level holds the pending/active buffers, the handshake, mask/LZ sampling and output decode.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL_COUNT=8, BLANK_COUNT=2.
- **Reset:** hold reset low for 3 cycles → digit_en=0000, seg_data=0, load_ready=1, frame_done=0. After release, the frame_done pulse arrives exactly every 32 cycles.
- **Scan order:** load 0x4321 with lz_en=0 and mask=0 → per slot, 2 dark cycles then 6 cycles of digit_en = 0001/0010/0100/1000 with seg_data = 1/2/3/4.
- **Tear-free update:**
  - Load 0x8765 mid-frame → load_ready drops the next cycle.
  - Display keeps the old values until the frame end, then shows 5,6,7,8.
  - load_ready rises the cycle after frame_done.
- **Back-to-back loads:** assert load_valid continuously with new data on the frame_done cycle → exactly one accept per frame; no value is lost or committed early.
- **Leading zeros and mask:**
  - active=0x0050, lz_en=1 → digits 3 and 2 stay dark; digit 1 shows 5; digit 0 shows 0.
  - Add mask=0010 → digit 1 also dark; slot timing unchanged.
- **Async reset mid-operation:** assert reset during DRIVE of digit 2 with a load pending → outputs go to reset values without waiting for a clock edge; pending data never appears.
